// File: rtl/uart_bus_initiator.sv
// Host-side master for the ASCII UART bus protocol: serialises read/write requests
// into uart_tx frames and parses "D"+4hex+CR+LF read replies coming from uart_rx.
module uart_bus_initiator #(
  parameter int TIMEOUT_CYCLES = 8192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req_addr_i,
  input  logic [15:0] req_data_i,
  input  logic        req_rw_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  output logic [15:0] resp_data_o,
  output logic        resp_valid_o,
  output logic        resp_err_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_start_o,
  input  logic        tx_done_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RESP} state_t;

  state_t        state, state_next;
  logic [15:0]   addr, wdata;
  logic          rw;
  logic [3:0]    ptr, ptr_next;
  logic [TW-1:0] timer, timer_next;
  logic [2:0]    idx, idx_next;
  logic [15:0]   shift, shift_next;
  logic [15:0]   resp_data, resp_data_next;
  logic          resp_valid, resp_valid_next;
  logic          resp_err, resp_err_next;
  logic          accept, handshake, last_byte;
  logic [4:0]    rx_hex;
  logic [7:0]    tx_byte;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    hex_char = (n < 4'd10) ? (8'h30 + {4'd0, n}) : (8'h37 + {4'd0, n});
  endfunction

  // Bit 4 flags a legal uppercase hex digit, bits 3:0 carry its value.
  function automatic logic [4:0] hex_value(input logic [7:0] c);
    hex_value = 5'd0;
    if (c >= 8'h30 && c <= 8'h39)
      hex_value = {1'b1, c[3:0]};
    else if (c >= 8'h41 && c <= 8'h46)
      hex_value = {1'b1, c[3:0] + 4'd9};
  endfunction

  // Holding ready low during the completion pulse keeps a new request from
  // being accepted before the previous one has been reported.
  assign req_ready_o  = (state == IDLE) && !resp_valid;
  assign accept       = req_valid_i && req_ready_o;
  assign tx_start_o   = (state == SEND);
  assign handshake    = tx_start_o && tx_done_i;
  assign last_byte    = rw ? (ptr == 4'd9) : (ptr == 4'd5);
  assign rx_hex       = hex_value(rx_data_i);
  assign tx_data_o    = tx_byte;
  assign resp_data_o  = resp_data;
  assign resp_valid_o = resp_valid;
  assign resp_err_o   = resp_err;

  always_comb begin
    tx_byte = 8'h0D;
    case (ptr)
      4'd0:    tx_byte = rw ? 8'h57 : 8'h52;
      4'd1:    tx_byte = hex_char(addr[15:12]);
      4'd2:    tx_byte = hex_char(addr[11:8]);
      4'd3:    tx_byte = hex_char(addr[7:4]);
      4'd4:    tx_byte = hex_char(addr[3:0]);
      4'd5:    tx_byte = rw ? hex_char(wdata[15:12]) : 8'h0D;
      4'd6:    tx_byte = hex_char(wdata[11:8]);
      4'd7:    tx_byte = hex_char(wdata[7:4]);
      4'd8:    tx_byte = hex_char(wdata[3:0]);
      default: tx_byte = 8'h0D;
    endcase
  end

  always_comb begin
    state_next      = state;
    ptr_next        = ptr;
    timer_next      = timer;
    idx_next        = idx;
    shift_next      = shift;
    resp_valid_next = 1'b0;
    resp_err_next   = resp_err;
    resp_data_next  = resp_data;

    case (state)
      IDLE: begin
        if (accept) begin
          state_next = SEND;
          ptr_next   = 4'd0;
        end
      end

      SEND: begin
        if (handshake) begin
          ptr_next = ptr + 4'd1;
          if (last_byte) begin
            if (rw) begin
              state_next      = IDLE;
              resp_valid_next = 1'b1;
              resp_err_next   = 1'b0;
              resp_data_next  = 16'h0000;
            end else begin
              state_next = WAIT_RESP;
              timer_next = '0;
              idx_next   = 3'd0;
            end
          end
        end
      end

      WAIT_RESP: begin
        logic lf_ok;
        logic bad;
        lf_ok      = 1'b0;
        bad        = 1'b0;
        timer_next = timer + 1'b1;
        if (rx_valid_i) begin
          case (idx)
            3'd0: if (rx_data_i == 8'h44) idx_next = 3'd1;
            3'd1, 3'd2, 3'd3, 3'd4: begin
              if (rx_hex[4]) begin
                shift_next = {shift[11:0], rx_hex[3:0]};
                idx_next   = idx + 3'd1;
              end else begin
                bad = 1'b1;
              end
            end
            3'd5: if (rx_data_i == 8'h0D) idx_next = 3'd6; else bad = 1'b1;
            3'd6: if (rx_data_i == 8'h0A) lf_ok = 1'b1; else bad = 1'b1;
            default: bad = 1'b1;
          endcase
        end
        // A valid LF landing on the final timer cycle still completes cleanly.
        if (lf_ok) begin
          state_next      = IDLE;
          resp_valid_next = 1'b1;
          resp_err_next   = 1'b0;
          resp_data_next  = shift;
        end else if (bad || timer == TW'(TIMEOUT_CYCLES - 1)) begin
          state_next      = IDLE;
          resp_valid_next = 1'b1;
          resp_err_next   = 1'b1;
          resp_data_next  = 16'h0000;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= 4'd0;
      timer      <= '0;
      idx        <= 3'd0;
      shift      <= 16'h0000;
      resp_data  <= 16'h0000;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      state      <= state_next;
      ptr        <= ptr_next;
      timer      <= timer_next;
      idx        <= idx_next;
      shift      <= shift_next;
      resp_data  <= resp_data_next;
      resp_valid <= resp_valid_next;
      resp_err   <= resp_err_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr  <= 16'h0000;
      wdata <= 16'h0000;
      rw    <= 1'b0;
    end else if (accept) begin
      addr  <= req_addr_i;
      wdata <= req_data_i;
      rw    <= req_rw_i;
    end
  end

endmodule

// File: tb/tb_uart_bus_initiator.sv
// Scoreboard bench for uart_bus_initiator with a behavioural uart_tx and directed replies.
module tb_uart_bus_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req_addr, req_data;
  logic        req_rw, req_valid;
  logic        req_ready;
  logic [15:0] resp_data;
  logic        resp_valid, resp_err;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_valid;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_count = 0;
  int last_hs_cyc = 0;
  int resp_cyc = 0;

  logic [7:0]  exp_bytes[$];
  logic [16:0] exp_resp[$];

  logic busy = 1'b0;
  int   bit_cnt = 0;

  uart_bus_initiator #(.TIMEOUT_CYCLES(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_addr_i   (req_addr),
    .req_data_i   (req_data),
    .req_rw_i     (req_rw),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .resp_data_o  (resp_data),
    .resp_valid_o (resp_valid),
    .resp_err_o   (resp_err),
    .tx_data_o    (tx_data),
    .tx_start_o   (tx_start),
    .tx_done_i    (tx_done),
    .rx_data_i    (rx_data),
    .rx_valid_i   (rx_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // uart_tx model: captures a byte when idle and start is high, pulses done three cycles later.
  always @(negedge clk) begin
    tx_done <= 1'b0;
    if (busy) begin
      if (bit_cnt == 0) begin
        tx_done <= 1'b1;
        busy    <= 1'b0;
        if (tx_start) begin
          hs_count    <= hs_count + 1;
          last_hs_cyc <= cyc;
        end
      end else begin
        bit_cnt <= bit_cnt - 1;
      end
    end else if (tx_start) begin
      if (exp_bytes.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL tx_byte_unexpected: got %0h, expected no byte", tx_data);
      end else begin
        checkOutput("tx_byte", {24'd0, tx_data}, {24'd0, exp_bytes.pop_front()});
      end
      busy    <= 1'b1;
      bit_cnt <= 2;
    end
  end

  always @(negedge clk) begin
    if (resp_valid) begin
      logic [16:0] e;
      resp_cyc = cyc;
      if (exp_resp.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL resp_unexpected: got err=%0b data=%0h, expected no response", resp_err, resp_data);
      end else begin
        e = exp_resp.pop_front();
        checkOutput("resp_err", {31'd0, resp_err}, {31'd0, e[16]});
        checkOutput("resp_data", {16'd0, resp_data}, {16'd0, e[15:0]});
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] addr, input logic [15:0] data, input logic rw,
                               input string frame, input logic [16:0] resp);
    int t;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) checkOutput("req_ready_wait", {31'd0, req_ready}, 32'd1);
    for (int i = 0; i < frame.len(); i++) exp_bytes.push_back(frame[i]);
    exp_bytes.push_back(8'h0D);
    exp_resp.push_back(resp);
    req_addr  = addr;
    req_data  = data;
    req_rw    = rw;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic waitHandshakes(input int target);
    int t;
    t = 0;
    while (hs_count < target && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) checkOutput("handshake_wait", hs_count, target);
  endtask

  task automatic waitResponses();
    int t;
    t = 0;
    while (exp_resp.size() != 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) checkOutput("resp_wait", exp_resp.size(), 0);
  endtask

  task automatic sendRxByte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic sendReply(input string s);
    for (int i = 0; i < s.len(); i++) sendRxByte(s[i]);
    sendRxByte(8'h0D);
    sendRxByte(8'h0A);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int t;
    rst       = 1'b1;
    req_addr  = 16'h0000;
    req_data  = 16'h0000;
    req_rw    = 1'b0;
    req_valid = 1'b0;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("reset_tx_start", {31'd0, tx_start}, 32'd0);
    checkOutput("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("reset_resp_err", {31'd0, resp_err}, 32'd0);
    checkOutput("reset_resp_data", {16'd0, resp_data}, 32'd0);
    rst = 1'b0;

    $display("[TB] write 0005 <= BEEF");
    base = hs_count;
    applyStimulus(16'h0005, 16'hBEEF, 1'b1, "W0005BEEF", {1'b0, 16'h0000});
    waitResponses();
    repeat (5) @(negedge clk);
    checkOutput("write_handshakes", hs_count - base, 10);
    checkOutput("write_bytes_left", exp_bytes.size(), 0);

    $display("[TB] read 00A1, reply D1234");
    base = hs_count;
    applyStimulus(16'h00A1, 16'h0000, 1'b0, "R00A1", {1'b0, 16'h1234});
    waitHandshakes(base + 6);
    sendReply("D1234");
    waitResponses();
    checkOutput("read_handshakes", hs_count - base, 6);

    $display("[TB] read 7F3C, garbage before DFFFF");
    base = hs_count;
    applyStimulus(16'h7F3C, 16'h0000, 1'b0, "R7F3C", {1'b0, 16'hFFFF});
    waitHandshakes(base + 6);
    sendRxByte(8'h55);
    sendRxByte(8'h0A);
    sendReply("DFFFF");
    waitResponses();

    $display("[TB] read 00B2, malformed reply D12g4");
    base = hs_count;
    applyStimulus(16'h00B2, 16'h0000, 1'b0, "R00B2", {1'b1, 16'h0000});
    waitHandshakes(base + 6);
    sendReply("D12g4");
    waitResponses();
    repeat (10) @(negedge clk);

    $display("[TB] read 0BAD with no reply");
    base = hs_count;
    applyStimulus(16'h0BAD, 16'h0000, 1'b0, "R0BAD", {1'b1, 16'h0000});
    waitHandshakes(base + 6);
    waitResponses();
    checkOutput("timeout_latency", resp_cyc - (last_hs_cyc + 1), 64);

    $display("[TB] reset during write, then read C3D2");
    base = hs_count;
    applyStimulus(16'h1234, 16'h5678, 1'b1, "W12345678", {1'b0, 16'h0000});
    waitHandshakes(base + 2);
    @(negedge clk);
    rst = 1'b1;
    exp_bytes.delete();
    exp_resp.delete();
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_tx_start", {31'd0, tx_start}, 32'd0);
    checkOutput("abort_ready", {31'd0, req_ready}, 32'd1);
    t = 0;
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    base = hs_count;
    applyStimulus(16'hC3D2, 16'h0000, 1'b0, "RC3D2", {1'b0, 16'h0042});
    waitHandshakes(base + 6);
    sendReply("D0042");
    waitResponses();
    checkOutput("post_reset_bytes_left", exp_bytes.size(), 0);
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
